// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared definitions for the ALU control decoder and the iterative MDU:
// ALU operation codes, ALUOp/func7/func3 encodings, MDU FSM states and
// the base-op func3 map shared by R-type and I-type decoding.
package alu_ctrl_mdu_pkg;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SLL  = 4'b0100;
  localparam logic [3:0] CTRL_SRL  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SRA  = 4'b0111;
  localparam logic [3:0] CTRL_SLT  = 4'b1000;
  localparam logic [3:0] CTRL_SLTU = 4'b1001;
  localparam logic [3:0] CTRL_MDU  = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // func3 -> operation for the plain (func7 = 0) integer ops
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = CTRL_ADD;
      3'b001:  op = CTRL_SLL;
      3'b010:  op = CTRL_SLT;
      3'b011:  op = CTRL_SLTU;
      3'b100:  op = CTRL_XOR;
      3'b101:  op = CTRL_SRL;
      3'b110:  op = CTRL_OR;
      default: op = CTRL_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_mdu_iter.sv
// Iterative multiply/divide unit. Operands are reduced to magnitudes on
// accept, processed one bit per CALC cycle (shift-add multiply or
// restoring divide sharing the r_hi/r_lo pair), and the sign is restored
// in FIX. Divide-by-zero and signed overflow bypass straight to DONE.
module alu_ctrl_mdu_iter
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_opa,
  input  logic [XLEN-1:0] i_opb,
  input  logic            i_flush,
  input  logic            i_out_ready,
  output logic            o_in_ready,
  output logic            o_out_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [2:0]        r_func3;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;

  logic              w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic              w_div0, w_ovf;
  logic [XLEN-1:0]   w_ma, w_mb, w_special;
  logic [XLEN:0]     w_msum;
  logic [XLEN:0]     w_dtrial;
  logic              w_dneg;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fixed;

  function automatic logic [XLEN-1:0] f_cneg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_cneg2(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  // Operand classification, magnitudes and special-case results at accept
  always_comb begin
    w_is_div  = i_func3[2];
    w_a_sgn   = w_is_div ? ~i_func3[0] : (i_func3 != F3_MULHU);
    w_b_sgn   = w_is_div ? ~i_func3[0] : ~i_func3[1];
    w_a_neg   = w_a_sgn & i_opa[XLEN-1];
    w_b_neg   = w_b_sgn & i_opb[XLEN-1];
    w_ma      = f_cneg(w_a_neg, i_opa);
    w_mb      = f_cneg(w_b_neg, i_opb);
    w_div0    = w_is_div && (i_opb == '0);
    w_ovf     = w_is_div && !i_func3[0] && (i_opa == MIN_VAL) && (i_opb == '1);
    w_special = '0;
    if (w_div0)
      w_special = i_func3[1] ? i_opa : '1;
    else
      w_special = i_func3[1] ? '0 : MIN_VAL;
  end

  // One iteration step of each algorithm and the sign-fixed final result
  always_comb begin
    w_msum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    w_dtrial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};
    w_dneg   = w_dtrial[XLEN];
    w_prod   = f_cneg2(r_neg_q, {r_hi, r_lo});
    w_quo    = f_cneg(r_neg_q, r_lo);
    w_rem    = f_cneg(r_neg_r, r_hi);
    if (r_func3[2])
      w_fixed = r_func3[1] ? w_rem : w_quo;
    else
      w_fixed = (r_func3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  // MDU control FSM with iteration datapath and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_func3     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_func3 <= i_func3;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_hi    <= '0;
            if (w_div0 || w_ovf) begin
              r_result    <= w_special;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
              if (w_is_div) begin
                r_lo <= w_ma;
                r_b  <= w_mb;
              end else begin
                r_lo <= w_mb;
                r_b  <= w_ma;
              end
            end
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else begin
            if (r_func3[2]) begin
              r_hi <= w_dneg ? {r_hi[XLEN-2:0], r_lo[XLEN-1]} : w_dtrial[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], ~w_dneg};
            end else begin
              r_hi <= w_msum[XLEN:1];
              r_lo <= {w_msum[0], r_lo[XLEN-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN-1))
              r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_result    <= w_fixed;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        default: begin
          // DONE: hold the result until taken; flush discards it
          if (i_flush || i_out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control for RV32I/M: combinational decode of ALUOp/func7/func3 into
// an ALU operation code, plus the handshake wiring to the iterative MDU.
module alu_ctrl_mdu
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4,
  parameter int M_EN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ALUOp,
  input  logic [6:0]        func7,
  input  logic [2:0]        func3,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              illegal,
  output logic              is_m,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              busy
);

  logic [3:0] w_ctrl;
  logic       w_illegal;
  logic       w_is_m;
  logic       w_start;

  // Instruction decode; every encoding yields a defined code, unknown ones flag illegal
  always_comb begin
    w_ctrl    = CTRL_ADD;
    w_illegal = 1'b0;
    w_is_m    = 1'b0;
    case (ALUOp)
      ALUOP_MEM: w_ctrl = CTRL_ADD;
      ALUOP_BR:  w_ctrl = CTRL_SUB;
      ALUOP_R: begin
        if (func7 == F7_BASE)
          w_ctrl = base_op(func3);
        else if (func7 == F7_ALT && func3 == 3'b000)
          w_ctrl = CTRL_SUB;
        else if (func7 == F7_ALT && func3 == 3'b101)
          w_ctrl = CTRL_SRA;
        else if (func7 == F7_MULDIV && M_EN != 0) begin
          w_ctrl = CTRL_MDU;
          w_is_m = 1'b1;
        end else
          w_illegal = 1'b1;
      end
      default: begin
        // I-type: func7 is immediate bits except for the shift encodings
        if (func3 == 3'b000)
          w_ctrl = CTRL_ADD;
        else if (func3 == 3'b101 && func7 == F7_ALT)
          w_ctrl = CTRL_SRA;
        else if ((func3 == 3'b001 || func3 == 3'b101) && func7 != F7_BASE)
          w_illegal = 1'b1;
        else
          w_ctrl = base_op(func3);
      end
    endcase
  end

  assign ctrl_out = CTRL_W'(w_ctrl);
  assign illegal  = w_illegal;
  assign is_m     = w_is_m;
  assign w_start  = in_valid & w_is_m;

  generate
    if (M_EN != 0) begin : g_mdu
      alu_ctrl_mdu_iter #(
        .XLEN(XLEN)
      ) u_mdu (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_func3     (func3),
        .i_opa       (opa),
        .i_opb       (opb),
        .i_flush     (flush),
        .i_out_ready (out_ready),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_result    (result),
        .o_busy      (busy)
      );
    end else begin : g_no_mdu
      assign in_ready  = 1'b0;
      assign out_valid = 1'b0;
      assign result    = '0;
      assign busy      = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Bench for alu_ctrl_mdu: decode table, MDU ops through a result
// scoreboard, special cases, back-pressure, flush and mid-op reset.
module tb_alu_ctrl_mdu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      ALUOp;
  logic [6:0]      func7;
  logic [2:0]      func3;
  logic [3:0]      ctrl_out;
  logic            illegal;
  logic            is_m;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] sb_q[$];

  alu_ctrl_mdu #(.XLEN(XLEN), .CTRL_W(4), .M_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ALUOp     (ALUOp),
    .func7     (func7),
    .func3     (func3),
    .ctrl_out  (ctrl_out),
    .illegal   (illegal),
    .is_m      (is_m),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opa       (opa),
    .opb       (opb),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural reference for the M-extension ops
  function automatic logic [31:0] mdu_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 2;
  endfunction

  task automatic dec_chk(input int idx, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [3:0] exp_ctrl,
                         input logic exp_ill, input logic exp_m);
    ALUOp = op; func7 = f7; func3 = f3;
    #1;
    check_eq($sformatf("dec%0d_ctrl", idx), ctrl_out, exp_ctrl);
    check_eq($sformatf("dec%0d_illegal", idx), illegal, exp_ill);
    check_eq($sformatf("dec%0d_is_m", idx), is_m, exp_m);
  endtask

  // Present an M op; push its expected result on the accept edge
  task automatic drive_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, output int waits);
    ALUOp = 2'b10; func7 = 7'b0000001; func3 = f3; opa = a; opb = b; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 60) begin
      @(posedge clk); #1;
      waits++;
    end
    check_eq({tag, "_in_ready"}, in_ready, 1);
    if (in_ready) begin
      @(posedge clk);
      sb_q.push_back(expv);
      #1;
    end
    in_valid = 1'b0; ALUOp = 2'b00; func7 = '0; func3 = '0;
    opa = $urandom; opb = $urandom;
  endtask

  // Wait for out_valid counting edges from accept (accept edge = 1), compare result
  task automatic wait_result(input string tag, input int exp_lat, output logic [31:0] expv);
    int n;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_lat"}, n, exp_lat);
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_size"}, sb_q.size(), 1);
      expv = '0;
    end else begin
      expv = sb_q.pop_front();
      check_eq(tag, result, expv);
    end
  endtask

  task automatic handoff(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_ov_clr"}, out_valid, 0);
    check_eq({tag, "_idle"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input int lat);
    int w;
    logic [31:0] e;
    drive_op(tag, f3, a, b, expv, w);
    wait_result(tag, lat, e);
    handoff(tag);
  endtask

  initial begin
    int w, seen;
    logic [31:0] e, ra, rb;
    logic [2:0] rf;

    rst_n = 1'b0; ALUOp = '0; func7 = '0; func3 = '0; in_valid = 1'b0;
    opa = '0; opb = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    rst_n = 1'b1;

    dec_chk(0,  2'b10, 7'b0100000, 3'b000, 4'b0110, 0, 0);
    dec_chk(1,  2'b11, 7'b0100000, 3'b000, 4'b0010, 0, 0);
    dec_chk(2,  2'b11, 7'b0100000, 3'b101, 4'b0111, 0, 0);
    dec_chk(3,  2'b10, 7'b0000010, 3'b000, 4'b0010, 1, 0);
    dec_chk(4,  2'b00, 7'b1111111, 3'b111, 4'b0010, 0, 0);
    dec_chk(5,  2'b01, 7'b0000000, 3'b000, 4'b0110, 0, 0);
    dec_chk(6,  2'b10, 7'b0000000, 3'b111, 4'b0000, 0, 0);
    dec_chk(7,  2'b10, 7'b0000000, 3'b011, 4'b1001, 0, 0);
    dec_chk(8,  2'b10, 7'b0000001, 3'b110, 4'b1111, 0, 1);
    dec_chk(9,  2'b10, 7'b0100000, 3'b001, 4'b0010, 1, 0);
    dec_chk(10, 2'b11, 7'b0000000, 3'b101, 4'b0101, 0, 0);
    dec_chk(11, 2'b11, 7'b0100000, 3'b001, 4'b0010, 1, 0);
    dec_chk(12, 2'b11, 7'b1111111, 3'b010, 4'b1000, 0, 0);
    dec_chk(13, 2'b11, 7'b0000001, 3'b001, 4'b0010, 1, 0);
    dec_chk(14, 2'b10, 7'b0100000, 3'b101, 4'b0111, 0, 0);
    dec_chk(15, 2'b10, 7'b0000000, 3'b100, 4'b0011, 0, 0);

    // in_valid with a non-M op must not start the MDU
    ALUOp = 2'b10; func7 = 7'b0000000; func3 = 3'b000; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("nonm_busy", busy, 0);
    in_valid = 1'b0;

    run_op("mul",    3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFEB, 34);
    run_op("mulh",   3'd1, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 34);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 34);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34);
    run_op("divu",   3'd5, 32'd100,       32'd7,          32'd14,        34);
    run_op("remu",   3'd7, 32'd100,       32'd7,          32'd2,         34);
    run_op("divu0",  3'd5, 32'd5,         32'd0,          32'hFFFF_FFFF, 1);
    run_op("rem0",   3'd6, 32'd5,         32'd0,          32'd5,         1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         1);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34);

    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 4) rb = 32'd0;
      run_op($sformatf("rnd%0d", i), rf, ra, rb, mdu_model(rf, ra, rb), model_lat(rf, ra, rb));
    end

    // Back-pressure: result held while out_ready is low
    out_ready = 1'b0;
    drive_op("bp_mul", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, w);
    wait_result("bp_mul", 34, e);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_result", result, e);
      check_eq("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    drive_op("bp_divu", 3'd5, 32'd100, 32'd7, 32'd14, w);
    check_eq("bp_accept_wait", w, 1);
    wait_result("bp_divu", 34, e);
    handoff("bp_divu");

    // Flush during CALC
    drive_op("fl", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, w);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("fl_in_ready", in_ready, 1);
    check_eq("fl_out_valid", out_valid, 0);
    check_eq("fl_busy", busy, 0);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("fl_no_out_valid", seen, 0);

    // Reset in the middle of CALC
    drive_op("rs", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, w);
    repeat (5) @(posedge clk);
    #1;
    check_eq("rs_busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rs_busy", busy, 0);
    check_eq("rs_out_valid", out_valid, 0);
    check_eq("rs_result", result, 0);
    check_eq("rs_in_ready", in_ready, 1);
    rst_n = 1'b1;
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    run_op("post_rst", 3'd7, 32'd100, 32'd7, 32'd2, 34);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
